data_memory_bytesel: RTL and testbench

//  Byte-addressed data memory for the CPU load/store path. Generalises the word-only

---
 rtl/data_mem_pkg.sv | 40 ++++
 rtl/data_mem_lane_align.sv | 37 +++
 rtl/data_memory_bytesel.sv | 142 ++++++++++++++
 tb/tb_data_memory_bytesel.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared definitions for the byte-selectable data memory: access size codes,
// FSM state encoding and lane helpers used by the store/load alignment logic.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Byte enables for a store of the given size at byte offset off within a word.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Bit shift that moves lane data between bit 0 and its position in the word.
  // Halves use only addr[1] so a misaligned half still maps to a legal lane pair.
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
    logic [4:0] sh;
    case (size)
      SZ_BYTE: sh = {off, 3'b000};
      SZ_HALF: sh = {off[1], 4'b0000};
      default: sh = 5'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/data_mem_lane_align.sv
// Combinational lane steering: extracts and extends load data from a stored
// word, and positions store data with the matching byte enables.
module data_mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be
);

  logic [4:0]  w_sh;
  logic [31:0] w_lane;
  logic        w_sign_b;
  logic        w_sign_h;

  // Lane extraction with sign/zero extension, plus store data placement.
  always_comb begin
    w_sh     = lane_shift(i_size, i_off);
    w_lane   = i_word >> w_sh;
    w_sign_b = ~i_unsigned & w_lane[7];
    w_sign_h = ~i_unsigned & w_lane[15];
    o_be     = byte_en(i_size, i_off);
    o_wdata  = i_wdata << w_sh;
    case (i_size)
      SZ_BYTE: o_rdata = {{24{w_sign_b}}, w_lane[7:0]};
      SZ_HALF: o_rdata = {{16{w_sign_h}}, w_lane[15:0]};
      SZ_WORD: o_rdata = i_word;
      default: o_rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_memory_bytesel.sv
// Byte-addressed data memory with byte/half/word access, alignment and range
// checks, programmable wait states and a valid/ready request/response handshake.
module data_memory_bytesel
  import data_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int         IDX_W   = $clog2(DEPTH);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [31:0] r_mem [DEPTH];

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic             w_accept;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_word;
  logic             w_oor;
  logic             w_misalign;
  logic             w_err;
  logic             w_we;
  logic [31:0]      w_load;
  logic [31:0]      w_wdata;
  logic [3:0]       w_be;

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  assign w_accept = req_valid & req_ready;
  assign w_idx    = req_addr[IDX_W+1:2];
  assign w_word   = r_mem[w_idx];

  // Any address bit above the array span means the access is out of range.
  generate
    if (ADDR_W > IDX_W + 2) begin : g_range
      assign w_oor = |req_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_range
      assign w_oor = 1'b0;
    end
  endgenerate

  // Alignment and size legality of the current request.
  always_comb begin
    case (req_size)
      SZ_BYTE: w_misalign = 1'b0;
      SZ_HALF: w_misalign = req_addr[0];
      SZ_WORD: w_misalign = |req_addr[1:0];
      default: w_misalign = 1'b1;
    endcase
    w_err = w_misalign | w_oor;
    w_we  = w_accept & req_write & ~w_err;
  end

  data_mem_lane_align u_align (
    .i_word     (w_word),
    .i_off      (req_addr[1:0]),
    .i_size     (req_size),
    .i_unsigned (req_unsigned),
    .i_wdata    (req_wdata),
    .o_rdata    (w_load),
    .o_wdata    (w_wdata),
    .o_be       (w_be)
  );

  // Storage array: byte-enabled write in the accept cycle, no reset on contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_we && w_be[b]) begin
        r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
      end
    end
  end

  // Request/response FSM with wait-state counter and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rsp_rdata <= (req_write || w_err) ? 32'h0000_0000 : w_load;
            r_rsp_err   <= w_err;
            if (WAIT_STATES == 0) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= WS_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_bytesel.sv
// Self-checking bench for data_memory_bytesel: directed vector table, reset and
// back-pressure sequences, and a randomized stream against a byte-array model.
module tb_data_memory_bytesel;
  import data_mem_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 256;
  localparam int WS     = 3;
  localparam int NBYTES = DEPTH * 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks;
  int n_err;
  int n_req;
  int n_rsp;

  logic [7:0] ref_mem [NBYTES];

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [25];

  data_memory_bytesel #(
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .WAIT_STATES (WS)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: error rule from size, alignment and range.
  function automatic logic model_err(input logic [31:0] a, input logic [1:0] sz);
    int nb;
    if (sz == 2'd3) return 1'b1;
    nb = 1 << sz;
    if (a >= 32'(NBYTES)) return 1'b1;
    return (a % nb) != 0;
  endfunction

  // Reference: little-endian gather of nb bytes, then extension.
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    int nb;
    logic [63:0] v;
    nb = 1 << sz;
    v = 64'd0;
    for (int i = 0; i < nb; i++) v = v | (64'(ref_mem[int'(a) + i]) << (8 * i));
    if (!uns && v[8*nb-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8 * nb));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int nb;
    nb = 1 << sz;
    for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
  endtask

  // One full transaction: request, wait for response, optional back-pressure, handshake.
  task automatic txn(input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd, input int hold,
                     input logic stray, output logic [31:0] rd, output logic er);
    int guard;
    int lat;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    req_valid    = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!req_ready) begin
      n_checks++;
      n_err++;
      $display("FAIL req_ready_timeout: got 0, expected 1");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_req++;
    // lat counts edges after the accept edge until rsp_valid is visible.
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(WS));
    rd = rsp_rdata;
    er = rsp_err;
    if (rsp_valid) n_rsp++;
    for (int h = 0; h < hold; h++) begin
      if (stray) begin
        req_write = 1'b1;
        req_size  = SZ_WORD;
        req_addr  = 32'h10;
        req_wdata = 32'h0;
        req_valid = 1'b1;
      end
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_err", 32'(rsp_err), 32'(er));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic        wr;
    logic        uns;
    logic        eerr;
    logic [31:0] erd;

    n_checks = 0; n_err = 0; n_req = 0; n_rsp = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = SZ_WORD;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;

    tbl[0]  = '{1'b1, SZ_WORD, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, SZ_BYTE, 1'b0, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0};
    tbl[2]  = '{1'b0, SZ_BYTE, 1'b1, 32'h13,  32'h0,        32'h000000DE, 1'b0};
    tbl[3]  = '{1'b0, SZ_HALF, 1'b0, 32'h10,  32'h0,        32'hFFFFBEEF, 1'b0};
    tbl[4]  = '{1'b0, SZ_HALF, 1'b1, 32'h12,  32'h0,        32'h0000DEAD, 1'b0};
    tbl[5]  = '{1'b1, SZ_WORD, 1'b0, 32'h20,  32'h11223344, 32'h0,        1'b0};
    tbl[6]  = '{1'b1, SZ_BYTE, 1'b0, 32'h21,  32'h0000005A, 32'h0,        1'b0};
    tbl[7]  = '{1'b0, SZ_WORD, 1'b0, 32'h20,  32'h0,        32'h11225A44, 1'b0};
    tbl[8]  = '{1'b0, SZ_HALF, 1'b0, 32'h11,  32'h0,        32'h0,        1'b1};
    tbl[9]  = '{1'b0, SZ_WORD, 1'b0, 32'h12,  32'h0,        32'h0,        1'b1};
    tbl[10] = '{1'b0, SZ_ILL,  1'b0, 32'h20,  32'h0,        32'h0,        1'b1};
    tbl[11] = '{1'b0, SZ_WORD, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1};
    tbl[12] = '{1'b1, SZ_WORD, 1'b0, 32'h12,  32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[13] = '{1'b1, SZ_ILL,  1'b0, 32'h20,  32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[14] = '{1'b1, SZ_WORD, 1'b0, 32'h410, 32'h00000000, 32'h0,        1'b1};
    tbl[15] = '{1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[16] = '{1'b0, SZ_WORD, 1'b0, 32'h20,  32'h0,        32'h11225A44, 1'b0};
    tbl[17] = '{1'b1, SZ_HALF, 1'b0, 32'h22,  32'h0000ABCD, 32'h0,        1'b0};
    tbl[18] = '{1'b0, SZ_WORD, 1'b0, 32'h20,  32'h0,        32'hABCD5A44, 1'b0};
    tbl[19] = '{1'b1, SZ_WORD, 1'b0, 32'h3FC, 32'h80000001, 32'h0,        1'b0};
    tbl[20] = '{1'b0, SZ_BYTE, 1'b0, 32'h3FF, 32'h0,        32'hFFFFFF80, 1'b0};
    tbl[21] = '{1'b0, SZ_HALF, 1'b0, 32'h3FE, 32'h0,        32'hFFFF8000, 1'b0};
    tbl[22] = '{1'b0, SZ_BYTE, 1'b1, 32'h3FC, 32'h0,        32'h00000001, 1'b0};
    tbl[23] = '{1'b0, SZ_HALF, 1'b1, 32'h11,  32'h0,        32'h0,        1'b1};
    tbl[24] = '{1'b0, SZ_WORD, 1'b0, 32'h80000010, 32'h0,   32'h0,        1'b1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);

    // Reset in the middle of a wait: response dropped, accepted store kept.
    req_write = 1'b1; req_size = SZ_WORD; req_addr = 32'h30;
    req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("midwait_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #2;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
    n_req = 0;
    txn(1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, 0, 1'b0, rd, er);
    chk("committed_store", rd, 32'hCAFEF00D);
    chk("committed_err", 32'(er), 32'd0);

    // Directed vector table.
    for (int i = 0; i < 25; i++) begin
      txn(tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, i % 3, 1'b0, rd, er);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
    end

    // Long back-pressure with a stray request that must be ignored.
    txn(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 5, 1'b1, rd, er);
    chk("bp_rdata", rd, 32'hABCD5A44);
    chk("bp_err", 32'(er), 32'd0);
    txn(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er);
    chk("stray_ignored", rd, 32'hDEADBEEF);

    // Randomized stream in 0x40..0x7F against the byte model.
    for (int w = 0; w < 16; w++) begin
      a  = 32'h40 + 32'(w * 4);
      wd = $urandom;
      model_store(a, SZ_WORD, wd);
      txn(1'b1, SZ_WORD, 1'b0, a, wd, 0, 1'b0, rd, er);
      chk("rinit_err", 32'(er), 32'd0);
    end
    for (int k = 0; k < 16; k++) begin
      wr  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 7) == 0) ? SZ_ILL : 2'($urandom_range(0, 2));
      a   = 32'h40 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = 32'h400 + 32'($urandom_range(0, 4095));
      if (!model_err(a, sz)) a = a & ~(32'((1 << sz) - 1));
      wd   = $urandom;
      eerr = model_err(a, sz);
      erd  = 32'h0;
      if (!eerr) begin
        if (wr) model_store(a, sz, wd);
        else    erd = model_load(a, sz, uns);
      end
      txn(wr, sz, uns, a, wd, int'($urandom_range(0, 3)), 1'b0, rd, er);
      chk($sformatf("rnd%0d_rdata", k), rd, erd);
      chk($sformatf("rnd%0d_err", k), 32'(er), 32'(eerr));
    end
    // Read back the whole random region.
    for (int w = 0; w < 16; w++) begin
      a = 32'h40 + 32'(w * 4);
      txn(1'b0, SZ_WORD, 1'b0, a, 32'h0, 0, 1'b0, rd, er);
      chk($sformatf("rchk%0d", w), rd, model_load(a, SZ_WORD, 1'b0));
    end
    chk("rsp_count", 32'(n_rsp), 32'(n_req));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
